// File: rtl/addr_scan_driver.sv
// Two-digit scan driver for the hex address display: latches an address,
// commits it at frame boundaries and time-multiplexes the digit anodes.
module addr_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int CNT_W     = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr_in,
  input  logic        addr_valid,
  input  logic        freeze,
  output logic [11:0] show_data,
  output logic        frame_done
);

  typedef enum logic [1:0] {S_D0, S_G0, S_D1, S_G1} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC == 0) ? '0 : CNT_W'(BLANK_CYC - 1);
  localparam bit               NO_BLANK   = (BLANK_CYC == 0);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shadow;
  logic [7:0]       disp;
  logic             pending;
  logic             cnt_last;
  logic             commit;
  logic             capture;
  logic [3:0]       anode;

  // Dwell/blank terminal count, next state and the frame commit point.
  always_comb begin
    state_next = state;
    cnt_last   = 1'b0;
    commit     = 1'b0;
    case (state)
      S_D0: begin
        cnt_last = (cnt == DWELL_LAST);
        if (cnt_last) state_next = NO_BLANK ? S_D1 : S_G0;
      end
      S_G0: begin
        cnt_last = (cnt == BLANK_LAST);
        if (cnt_last) state_next = S_D1;
      end
      S_D1: begin
        cnt_last = (cnt == DWELL_LAST);
        if (cnt_last) begin
          state_next = NO_BLANK ? S_D0 : S_G1;
          commit     = NO_BLANK;
        end
      end
      S_G1: begin
        cnt_last = (cnt == BLANK_LAST);
        if (cnt_last) begin
          state_next = S_D0;
          commit     = 1'b1;
        end
      end
      default: state_next = S_D0;
    endcase
  end

  assign capture = addr_valid && !freeze;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_D0;
      cnt        <= '0;
      shadow     <= 8'h00;
      disp       <= 8'h00;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_last ? '0 : cnt + CNT_W'(1);
      frame_done <= commit;
      // disp takes the pre-edge shadow even if a new capture lands on this edge.
      if (commit && pending) disp <= shadow;
      if (capture) begin
        shadow  <= addr_in;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    anode = 4'b0000;
    case (state)
      S_D0:    anode = 4'b0001;
      S_D1:    anode = 4'b0010;
      default: anode = 4'b0000;
    endcase
  end

  assign show_data = {anode, disp};

endmodule

// File: tb/tb_addr_scan_driver.sv
// Randomized bench for addr_scan_driver: a blanking build and a no-blank build
// run side by side against a frame-position reference model.
module tb_addr_scan_driver;

  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  addr_in;
  logic        addr_valid;
  logic        freeze;
  logic [11:0] show_data0, show_data1;
  logic        frame_done0, frame_done1;

  int vectors = 0;
  int miscompares = 0;

  // Reference state per build: cycles since reset, shadow, displayed value, pending.
  int         blank_len [2] = '{2, 0};
  int         tt [2];
  logic [7:0] m_shadow [2];
  logic [7:0] m_disp [2];
  bit         m_pending [2];

  addr_scan_driver #(.SCAN_DIV(SCAN), .BLANK_CYC(2), .CNT_W(17)) dut0 (
    .clk(clk), .reset(reset_n), .addr_in(addr_in), .addr_valid(addr_valid),
    .freeze(freeze), .show_data(show_data0), .frame_done(frame_done0));

  addr_scan_driver #(.SCAN_DIV(SCAN), .BLANK_CYC(0), .CNT_W(17)) dut1 (
    .clk(clk), .reset(reset_n), .addr_in(addr_in), .addr_valid(addr_valid),
    .freeze(freeze), .show_data(show_data1), .frame_done(frame_done1));

  always #5 clk = ~clk;

  function automatic int frame_len(int m);
    return 2 * (SCAN + blank_len[m]);
  endfunction

  function automatic logic [12:0] expect_out(int m);
    int p;
    logic [3:0] an;
    p = tt[m] % frame_len(m);
    if (p < SCAN) an = 4'b0001;
    else if (p < SCAN + blank_len[m]) an = 4'b0000;
    else if (p < 2 * SCAN + blank_len[m]) an = 4'b0010;
    else an = 4'b0000;
    return {an, m_disp[m], (tt[m] > 0 && p == 0)};
  endfunction

  function automatic logic [25:0] expect_both();
    return {expect_out(0), expect_out(1)};
  endfunction

  function automatic logic [25:0] actual_both();
    return {show_data0, frame_done0, show_data1, frame_done1};
  endfunction

  task automatic model_step(int m);
    bit commit, cap;
    if (!reset_n) begin
      tt[m] = 0; m_shadow[m] = 8'h00; m_disp[m] = 8'h00; m_pending[m] = 0;
    end else begin
      commit = ((tt[m] + 1) % frame_len(m)) == 0;
      cap    = addr_valid && !freeze;
      if (commit && m_pending[m]) m_disp[m] = m_shadow[m];
      if (cap) begin
        m_shadow[m]  = addr_in;
        m_pending[m] = 1;
      end else if (commit) begin
        m_pending[m] = 0;
      end
      tt[m]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic idle_inputs();
    addr_valid = 1'b0; freeze = 1'b0; addr_in = $urandom_range(0, 255);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (actual_both() !== {12'h100, 1'b0, 12'h100, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL reset cyc=%0d got=%h exp=%h", i, actual_both(), {12'h100, 1'b0, 12'h100, 1'b0});
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    for (int i = 1; i <= 26; i++) begin
      tick();
      vectors++;
      if (actual_both() !== expect_both() || (i == 12 && frame_done0 !== 1'b1)) begin
        miscompares++;
        $display("[TB] FAIL idle_scan cyc=%0d got=%h exp=%h", i, actual_both(), expect_both());
      end
    end
  endtask

  task automatic test_capture();
    for (int i = 0; i < 12 && (tt[0] % 12) != 2; i++) tick();
    addr_in = 8'hA5; addr_valid = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 14; i++) begin
      vectors++;
      if (actual_both() !== expect_both()) begin
        miscompares++;
        $display("[TB] FAIL capture cyc=%0d got=%h exp=%h", i, actual_both(), expect_both());
      end
      tick();
    end
  endtask

  task automatic test_commit_edge_capture();
    addr_in = 8'h11; addr_valid = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 12 && ((tt[0] + 1) % 12) != 0; i++) tick();
    addr_in = 8'h3C; addr_valid = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 26; i++) begin
      vectors++;
      if (actual_both() !== expect_both() || (i == 0 && show_data0 !== 12'h111)) begin
        miscompares++;
        $display("[TB] FAIL commit_edge cyc=%0d got=%h exp=%h", i, actual_both(), expect_both());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      addr_in = $urandom_range(0, 255); addr_valid = 1'b1;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 26; i++) begin
      vectors++;
      if (actual_both() !== expect_both()) begin
        miscompares++;
        $display("[TB] FAIL back_to_back cyc=%0d got=%h exp=%h", i, actual_both(), expect_both());
      end
      tick();
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1; addr_in = 8'hFF; addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    for (int i = 0; i < 36; i++) begin
      vectors++;
      if (actual_both() !== expect_both()) begin
        miscompares++;
        $display("[TB] FAIL freeze cyc=%0d got=%h exp=%h", i, actual_both(), expect_both());
      end
      tick();
    end
    freeze = 1'b0; addr_in = 8'h42; addr_valid = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 14; i++) begin
      vectors++;
      if (actual_both() !== expect_both()) begin
        miscompares++;
        $display("[TB] FAIL unfreeze cyc=%0d got=%h exp=%h", i, actual_both(), expect_both());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    addr_in = 8'h5A; addr_valid = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 12 && (tt[0] % 12) != 0; i++) tick();
    for (int i = 0; i < 12 && (tt[0] % 12) != 7; i++) tick();
    vectors++;
    if (show_data0 !== 12'h25A) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_pre got=%h exp=%h", show_data0, 12'h25A);
    end
    reset_n = 1'b0;
    tick();
    vectors++;
    if ({show_data0, frame_done0} !== {12'h100, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid got=%h exp=%h", {show_data0, frame_done0}, {12'h100, 1'b0});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if (actual_both() !== expect_both()) begin
        miscompares++;
        $display("[TB] FAIL reset_restart cyc=%0d got=%h exp=%h", i, actual_both(), expect_both());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      addr_in    = $urandom_range(0, 255);
      addr_valid = ($urandom_range(0, 7) == 0);
      freeze     = ($urandom_range(0, 9) == 0);
      reset_n    = ($urandom_range(0, 149) != 0);
      tick();
      vectors++;
      if (actual_both() !== expect_both()) begin
        miscompares++;
        $display("[TB] FAIL random cyc=%0d got=%h exp=%h", i, actual_both(), expect_both());
      end
    end
    reset_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_capture();
    test_commit_edge_capture();
    test_back_to_back();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
